// File: rtl/hazard_stall_unit_if.sv
// Pipeline-side signal bundle for the hazard stall unit.
// The master modport is the stall unit's view; slave is the pipeline's view.
interface hazard_stall_unit_if;
  logic [5:0] IFID_Opcode;
  logic [4:0] IFID_Rs;
  logic [4:0] IFID_Rt;
  logic       IDEX_MemRead;
  logic [4:0] IDEX_Rt;
  logic       MEM_BranchTaken;
  logic       Controller_Write;
  logic       PC_Write;
  logic       IFID_Write;
  logic       IFID_Flush;
  logic       IDEX_Flush;
  logic       EXMEM_Flush;
  logic       Stall_Active;

  modport master (
    input  IFID_Opcode, IFID_Rs, IFID_Rt, IDEX_MemRead, IDEX_Rt, MEM_BranchTaken,
    output Controller_Write, PC_Write, IFID_Write,
    output IFID_Flush, IDEX_Flush, EXMEM_Flush, Stall_Active
  );

  modport slave (
    output IFID_Opcode, IFID_Rs, IFID_Rt, IDEX_MemRead, IDEX_Rt, MEM_BranchTaken,
    input  Controller_Write, PC_Write, IFID_Write,
    input  IFID_Flush, IDEX_Flush, EXMEM_Flush, Stall_Active
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Load-use stall sequencer and branch flush generator for the ID stage.
// Define HAZARD_PERF_CNT_EN to add the Stall_Cycles / Flush_Events counters.
module hazard_stall_unit #(
  parameter int LOAD_USE_STALLS = 1,
  parameter int CNT_W           = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  hazard_stall_unit_if.master pif
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]    Stall_Cycles,
  output logic [CNT_W-1:0]    Flush_Events
`endif
);

  if (LOAD_USE_STALLS < 1 || LOAD_USE_STALLS > 7 || CNT_W < 1) begin : g_bad_cfg
    $error("hazard_stall_unit: LOAD_USE_STALLS must be 1..7 and CNT_W >= 1");
  end

  typedef enum logic {RUN, STALL} state_t;

  // First bubble is issued from RUN, so STALL only has to cover the rest.
  localparam logic [2:0] RELOAD = (LOAD_USE_STALLS > 1) ? 3'(LOAD_USE_STALLS - 2) : 3'd0;

  state_t     state, state_next;
  logic [2:0] cnt, cnt_next;
  logic       uses_rt, hz;
  logic       ctrl_write, pc_write, ifid_write, flush;

  assign uses_rt = (pif.IFID_Opcode == 6'd0)  || (pif.IFID_Opcode == 6'd4) ||
                   (pif.IFID_Opcode == 6'd5)  || (pif.IFID_Opcode == 6'd43);

  assign hz = pif.IDEX_MemRead && (pif.IDEX_Rt != 5'd0) &&
              ((pif.IDEX_Rt == pif.IFID_Rs) || (uses_rt && (pif.IDEX_Rt == pif.IFID_Rt)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= 3'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // A taken branch outranks any stall and aborts one already in progress.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    ctrl_write = 1'b0;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    flush      = 1'b0;
    if (!rst_n) begin
      ctrl_write = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      flush      = 1'b1;
      state_next = RUN;
      cnt_next   = 3'd0;
    end else if (pif.MEM_BranchTaken) begin
      ctrl_write = 1'b1;
      flush      = 1'b1;
      state_next = RUN;
      cnt_next   = 3'd0;
    end else begin
      case (state)
        RUN: begin
          if (hz) begin
            ctrl_write = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            if (LOAD_USE_STALLS > 1) begin
              state_next = STALL;
              cnt_next   = RELOAD;
            end
          end
        end
        STALL: begin
          ctrl_write = 1'b1;
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          if (cnt == 3'd0) state_next = RUN;
          else             cnt_next   = cnt - 3'd1;
        end
        default: state_next = RUN;
      endcase
    end
  end

  assign pif.Controller_Write = ctrl_write;
  assign pif.PC_Write         = pc_write;
  assign pif.IFID_Write       = ifid_write;
  assign pif.IFID_Flush       = flush;
  assign pif.IDEX_Flush       = flush;
  assign pif.EXMEM_Flush      = flush;
  assign pif.Stall_Active     = rst_n && (state == STALL);

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Stall_Cycles <= '0;
      Flush_Events <= '0;
    end else begin
      if (!pc_write && (Stall_Cycles != '1)) Stall_Cycles <= Stall_Cycles + CNT_W'(1);
      if (pif.MEM_BranchTaken && (Flush_Events != '1)) Flush_Events <= Flush_Events + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: one instance with 1 bubble per hazard, one with 3,
// driven with identical directed then random stimulus and checked against a bubble-count model.
module tb_hazard_stall_unit;

  localparam int TB_CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_stall_unit_if pif1 ();
  hazard_stall_unit_if pif3 ();

`ifdef HAZARD_PERF_CNT_EN
  logic [TB_CNT_W-1:0] stallCyc1, flushEv1, stallCyc3, flushEv3;
`endif

  hazard_stall_unit #(.LOAD_USE_STALLS(1), .CNT_W(TB_CNT_W)) u1 (
    .clk(clk), .rst_n(rst_n), .pif(pif1)
`ifdef HAZARD_PERF_CNT_EN
    , .Stall_Cycles(stallCyc1), .Flush_Events(flushEv1)
`endif
  );

  hazard_stall_unit #(.LOAD_USE_STALLS(3), .CNT_W(TB_CNT_W)) u3 (
    .clk(clk), .rst_n(rst_n), .pif(pif3)
`ifdef HAZARD_PERF_CNT_EN
    , .Stall_Cycles(stallCyc3), .Flush_Events(flushEv3)
`endif
  );

  int assertions = 0;
  int failures   = 0;

  // Model state: bubbles still owed after the current cycle, plus counter images.
  int bubbles [2]   = '{1, 3};
  int rem     [2]   = '{0, 0};
  int remNext [2]   = '{0, 0};
  int stallCnt[2]   = '{0, 0};
  int flushCnt[2]   = '{0, 0};
  int stallNext[2]  = '{0, 0};
  int flushNext[2]  = '{0, 0};
  localparam int SAT = (1 << TB_CNT_W) - 1;

  logic [5:0] curOp;
  logic [4:0] curRs, curRt, curIrt;
  logic       curMr, curBr;

  function automatic logic hazardOf(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                    logic mr, logic [4:0] irt);
    logic usesRt;
    usesRt = (op inside {6'd0, 6'd4, 6'd5, 6'd43});
    return mr && (irt != 5'd0) && ((irt == rs) || (usesRt && (irt == rt)));
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    assertions++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input int k, input string step);
    logic eCtrl, ePc, eIfid, eFlush, eSa;
    logic oCtrl, oPc, oIfid, oIff, oIdf, oExf, oSa;
    eSa = (rem[k] > 0) && rst_n;
    if (!rst_n) begin
      eCtrl = 1; ePc = 0; eIfid = 0; eFlush = 1; remNext[k] = 0;
    end else if (curBr) begin
      eCtrl = 1; ePc = 1; eIfid = 1; eFlush = 1; remNext[k] = 0;
    end else if (rem[k] > 0) begin
      eCtrl = 1; ePc = 0; eIfid = 0; eFlush = 0; remNext[k] = rem[k] - 1;
    end else if (hazardOf(curOp, curRs, curRt, curMr, curIrt)) begin
      eCtrl = 1; ePc = 0; eIfid = 0; eFlush = 0; remNext[k] = bubbles[k] - 1;
    end else begin
      eCtrl = 0; ePc = 1; eIfid = 1; eFlush = 0; remNext[k] = 0;
    end
    if (!rst_n) begin
      stallNext[k] = 0; flushNext[k] = 0;
    end else begin
      stallNext[k] = (!ePc && stallCnt[k] < SAT) ? stallCnt[k] + 1 : stallCnt[k];
      flushNext[k] = (curBr && flushCnt[k] < SAT) ? flushCnt[k] + 1 : flushCnt[k];
    end
    if (k == 0) begin
      oCtrl = pif1.Controller_Write; oPc = pif1.PC_Write; oIfid = pif1.IFID_Write;
      oIff = pif1.IFID_Flush; oIdf = pif1.IDEX_Flush; oExf = pif1.EXMEM_Flush; oSa = pif1.Stall_Active;
    end else begin
      oCtrl = pif3.Controller_Write; oPc = pif3.PC_Write; oIfid = pif3.IFID_Write;
      oIff = pif3.IFID_Flush; oIdf = pif3.IDEX_Flush; oExf = pif3.EXMEM_Flush; oSa = pif3.Stall_Active;
    end
    chk($sformatf("%s/n%0d/Controller_Write", step, bubbles[k]), 16'(oCtrl), 16'(eCtrl));
    chk($sformatf("%s/n%0d/PC_Write", step, bubbles[k]),         16'(oPc),   16'(ePc));
    chk($sformatf("%s/n%0d/IFID_Write", step, bubbles[k]),       16'(oIfid), 16'(eIfid));
    chk($sformatf("%s/n%0d/IFID_Flush", step, bubbles[k]),       16'(oIff),  16'(eFlush));
    chk($sformatf("%s/n%0d/IDEX_Flush", step, bubbles[k]),       16'(oIdf),  16'(eFlush));
    chk($sformatf("%s/n%0d/EXMEM_Flush", step, bubbles[k]),      16'(oExf),  16'(eFlush));
    chk($sformatf("%s/n%0d/Stall_Active", step, bubbles[k]),     16'(oSa),   16'(eSa));
`ifdef HAZARD_PERF_CNT_EN
    chk($sformatf("%s/n%0d/Stall_Cycles", step, bubbles[k]),
        16'(k == 0 ? stallCyc1 : stallCyc3), 16'(stallCnt[k]));
    chk($sformatf("%s/n%0d/Flush_Events", step, bubbles[k]),
        16'(k == 0 ? flushEv1 : flushEv3), 16'(flushCnt[k]));
`endif
  endtask

  // One pipeline cycle: drive on the falling edge, check, then advance the model at the rising edge.
  task automatic applyStimulus(input string step, input logic rst, input logic [5:0] op,
                               input logic [4:0] rs, input logic [4:0] rt, input logic mr,
                               input logic [4:0] irt, input logic br);
    @(negedge clk);
    rst_n = rst;
    curOp = op; curRs = rs; curRt = rt; curMr = mr; curIrt = irt; curBr = br;
    pif1.IFID_Opcode = op; pif1.IFID_Rs = rs; pif1.IFID_Rt = rt;
    pif1.IDEX_MemRead = mr; pif1.IDEX_Rt = irt; pif1.MEM_BranchTaken = br;
    pif3.IFID_Opcode = op; pif3.IFID_Rs = rs; pif3.IFID_Rt = rt;
    pif3.IDEX_MemRead = mr; pif3.IDEX_Rt = irt; pif3.MEM_BranchTaken = br;
    #1;
    checkOutput(0, step);
    checkOutput(1, step);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      rem[k] = remNext[k]; stallCnt[k] = stallNext[k]; flushCnt[k] = flushNext[k];
    end
  endtask

  initial begin
    logic [5:0] opTab [7];
    opTab = '{6'd0, 6'd4, 6'd5, 6'd43, 6'd35, 6'd2, 6'd8};

    // Reset held, then released into RUN
    applyStimulus("reset0", 0, 6'd0, 5'd1, 5'd2, 1, 5'd1, 0);
    applyStimulus("reset1", 0, 6'd0, 5'd1, 5'd2, 0, 5'd0, 0);
    applyStimulus("run",    1, 6'd0, 5'd1, 5'd2, 0, 5'd0, 0);

    // Load-use on rs followed by the bubble in EX
    applyStimulus("lu_rs",  1, 6'd0, 5'd8, 5'd3, 1, 5'd8, 0);
    for (int i = 0; i < 4; i++) applyStimulus("lu_rs_after", 1, 6'd0, 5'd8, 5'd3, 0, 5'd0, 0);

    // rt-only match: LW ignores rt, SW uses it; x0 never stalls
    applyStimulus("rt_lw",  1, 6'd35, 5'd1, 5'd9, 1, 5'd9, 0);
    applyStimulus("rt_sw",  1, 6'd43, 5'd1, 5'd9, 1, 5'd9, 0);
    for (int i = 0; i < 3; i++) applyStimulus("rt_sw_after", 1, 6'd43, 5'd1, 5'd9, 0, 5'd0, 0);
    applyStimulus("x0",     1, 6'd0, 5'd0, 5'd0, 1, 5'd0, 0);

    // Branch on the second stall cycle aborts the remaining bubble
    applyStimulus("br_hz",  1, 6'd0, 5'd4, 5'd5, 1, 5'd4, 0);
    applyStimulus("br_mid", 1, 6'd0, 5'd4, 5'd5, 0, 5'd0, 1);
    applyStimulus("br_run", 1, 6'd0, 5'd4, 5'd5, 0, 5'd0, 0);
    applyStimulus("br_run2",1, 6'd0, 5'd4, 5'd5, 0, 5'd0, 0);

    // Reset in the middle of a stall leaves nothing behind
    applyStimulus("rs_hz",  1, 6'd4, 5'd6, 5'd7, 1, 5'd7, 0);
    applyStimulus("rs_mid", 0, 6'd0, 5'd1, 5'd2, 0, 5'd0, 0);
    applyStimulus("rs_run", 1, 6'd0, 5'd1, 5'd2, 0, 5'd0, 0);

    // Long hazard run saturates the stall counter, plus two branches
    for (int i = 0; i < 20; i++) applyStimulus("sat", 1, 6'd0, 5'd3, 5'd3, 1, 5'd3, 0);
    applyStimulus("sat_br1", 1, 6'd0, 5'd1, 5'd2, 0, 5'd0, 1);
    applyStimulus("sat_br2", 1, 6'd0, 5'd1, 5'd2, 0, 5'd0, 1);
    applyStimulus("sat_end", 1, 6'd0, 5'd1, 5'd2, 0, 5'd0, 0);

    // Random traffic over a small register set so hazards are frequent
    for (int i = 0; i < 3000; i++) begin
      applyStimulus("rand",
                    ($urandom_range(0, 39) != 0),
                    opTab[$urandom_range(0, 6)],
                    5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)),
                    ($urandom_range(0, 1) == 1),
                    5'($urandom_range(0, 3)),
                    ($urandom_range(0, 9) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
